// File: rtl/stripes_pkg.sv
// Shared constants, types and precision decode for the Stripes neuron serializer.
package stripes_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned Tn = 16;
  localparam int unsigned PW = 5;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  typedef struct packed {
    logic [Tn-1:0][N-1:0] neurons;
    logic [PW-1:0]        prec;
  } brick_t;

  // Zero means full width; anything wider than a neuron is clamped to full width.
  function automatic logic [PW-1:0] prec_decode(input logic [PW-1:0] raw);
    if (raw == '0 || 32'(raw) > N) return PW'(N);
    return raw;
  endfunction

endpackage

// File: rtl/stripes_brick_slot.sv
// One brick plus decoded precision with a full flag; used for the active and pending slots.
module stripes_brick_slot
  import stripes_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  brick_t d,
  output brick_t q,
  output logic   full
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/stripes_neuron_serializer.sv
// Double-buffered MSB-first bit-serializer feeding the Stripes serial inner-product stage.
// Optional zero-brick skipping is enabled by defining STRIPES_SER_ZERO_SKIP_EN.
module stripes_neuron_serializer
  import stripes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N*Tn-1:0]    i_neurons,
  input  logic [PW-1:0]      i_precision,
  input  logic               i_stall,
  output logic               o_valid,
  output logic [Tn-1:0]      o_bits,
  output logic               o_first_cycle,
  output logic               o_last_cycle,
  output logic [PW-1:0]      o_bit_idx
`ifdef STRIPES_SER_ZERO_SKIP_EN
  ,
  output logic               o_skipped
`endif
);

  state_t        state, state_next;
  logic [PW-1:0] cnt, cnt_next;

  brick_t in_brick, act_d, act_q, pend_q, nxt;
  logic   act_full, pend_full, nxt_full;
  logic   act_load, act_sel_pend, act_clear, pend_load, pend_clear;
  logic   accept, take;

  logic [Tn-1:0] bits_d;
  logic          first_d, last_d;

  always_comb begin
    in_brick.neurons = i_neurons;
    in_brick.prec    = prec_decode(i_precision);
  end

  assign o_ready = ~pend_full;
  assign accept  = i_valid && !pend_full;
  assign act_d   = act_sel_pend ? pend_q : in_brick;

`ifdef STRIPES_SER_ZERO_SKIP_EN
  logic zero_brick;

  // A brick is all-zero if no lane has a set bit inside its streamed precision window.
  always_comb begin
    logic [N-1:0] mask;
    mask       = (32'(in_brick.prec) >= N) ? '1 : ((N'(1) << in_brick.prec) - N'(1));
    zero_brick = 1'b1;
    for (int k = 0; k < Tn; k++) begin
      if ((in_brick.neurons[k] & mask) != '0) zero_brick = 1'b0;
    end
  end

  assign take = accept && !zero_brick;

  always_ff @(posedge clk) begin
    if (!reset) o_skipped <= 1'b0;
    else        o_skipped <= accept && zero_brick;
  end
`else
  assign take = accept;
`endif

  stripes_brick_slot u_active (
    .clk   (clk),
    .reset (reset),
    .load  (act_load),
    .clear (act_clear),
    .d     (act_d),
    .q     (act_q),
    .full  (act_full)
  );

  stripes_brick_slot u_pending (
    .clk   (clk),
    .reset (reset),
    .load  (pend_load),
    .clear (pend_clear),
    .d     (in_brick),
    .q     (pend_q),
    .full  (pend_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and slot control; a finishing brick hands over to pending first, then to the input.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    act_load     = 1'b0;
    act_sel_pend = 1'b0;
    act_clear    = 1'b0;
    pend_load    = 1'b0;
    pend_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          act_load   = 1'b1;
          cnt_next   = in_brick.prec - PW'(1);
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (i_stall || cnt != '0) pend_load = take;
        if (!i_stall) begin
          if (cnt != '0) begin
            cnt_next = cnt - PW'(1);
          end else if (pend_full) begin
            act_load     = 1'b1;
            act_sel_pend = 1'b1;
            pend_clear   = 1'b1;
            cnt_next     = pend_q.prec - PW'(1);
          end else if (take) begin
            act_load = 1'b1;
            cnt_next = in_brick.prec - PW'(1);
          end else begin
            act_clear  = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the slot contents after this edge.
  always_comb begin
    nxt      = act_load ? act_d : act_q;
    nxt_full = act_load || (act_full && !act_clear);
    bits_d   = '0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    if (nxt_full) begin
      for (int k = 0; k < Tn; k++) begin
        bits_d[k] = nxt.neurons[k][CW'(cnt_next)];
      end
      first_d = (cnt_next == nxt.prec - PW'(1));
      last_d  = (cnt_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_valid       <= 1'b0;
      o_bits        <= '0;
      o_first_cycle <= 1'b0;
      o_last_cycle  <= 1'b0;
      o_bit_idx     <= '0;
    end else begin
      o_valid       <= nxt_full;
      o_bits        <= bits_d;
      o_first_cycle <= first_d;
      o_last_cycle  <= last_d;
      o_bit_idx     <= nxt_full ? cnt_next : '0;
    end
  end

endmodule

// File: doc/stripes_neuron_serializer.md
Name: stripes_neuron_serializer

Overview:
- Upstream neighbour of the Stripes NFU-1/2 bit-serial pipeline. Sits between the NBin read port and the serial inner-product stage.
- Accepts one brick of Tn parallel N-bit neurons plus its precision over a valid/ready handshake.
- Streams the brick out MSB-first, one bit per lane per cycle, for exactly p cycles. Generates the first/last-cycle control the serial pipe uses to reset and finish its accumulation.
- Double-buffered, so back-to-back bricks stream with no bubble.

Parameters:
- N, 16, neuron width in bits (max precision)
- Tn, 16, neuron lanes per brick
- PW, 5, precision field width (log2(N)+1)

Ports:
- clk  in  1  main clock
- reset  in  1  synchronous, active-low reset (asserted when 0), sampled on rising edge of clk
- i_valid  in  1  upstream brick valid
- o_ready  out  1  serializer can accept a brick this cycle
- i_neurons  in  N*Tn  brick; lane k at [(k+1)*N-1 : k*N]
- i_precision  in  PW  bits to stream for this brick
- i_stall  in  1  downstream hold; freezes output stream
- o_valid  out  1  o_bits valid this cycle
- o_bits  out  Tn  one serial bit per lane
- o_first_cycle  out  1  first bit of current brick
- o_last_cycle  out  1  last bit of current brick
- o_bit_idx  out  PW  bit position currently driven (p-1 down to 0)

Behaviour:
- Precision decode, latched at accept:
  - p = i_precision when 1..N.
  - 0 is treated as N.
  - Values above N clamp to N.
- Storage:
  - Active register holds the brick being streamed, its p, and down-counter cnt.
  - Pending register holds one more brick and its p.
- o_ready = !pend_full. Registered state only; no combinational path from i_valid.
- Accept rule (i_valid && o_ready at edge t):
  - If the active slot is empty, or is consuming its last bit at t without stall, the brick goes directly to active. o_valid=1 and o_first_cycle=1 at t+1.
  - Otherwise the brick goes to pending.
- FSM states: IDLE (active empty), STREAM.
  - IDLE -> STREAM on accept.
  - In STREAM, each non-stalled cycle decrements cnt, starting at p-1.
  - At cnt==0 without stall:
    - pending full: move pending into active (next cycle is first bit, no bubble).
    - else if accept at t: take the new brick directly into active.
    - else: go to IDLE.
- Outputs in STREAM:
  - o_valid=1.
  - o_bits[k] = lane k bit [cnt].
  - o_bit_idx = cnt.
  - o_first_cycle = (cnt==p-1).
  - o_last_cycle = (cnt==0). With p=1, first and last are both 1.
- Stall: i_stall=1 holds cnt, o_bits, o_first_cycle, o_last_cycle and o_valid unchanged. Accept into pending is still allowed during stall.
- Latency: accept at edge t gives the first bit valid in cycle t+1 when the active slot is free. Throughput is one brick per p cycles.
- Reset (reset==0), including mid-brick:
  - Both slots are emptied and the FSM goes to IDLE.
  - o_valid=0, o_first_cycle=0, o_last_cycle=0, o_bits=0, o_bit_idx=0.
  - o_ready=1 from the first cycle after reset deasserts.
  - The partial brick is discarded; no last-cycle pulse is emitted for it.
- Bits above p-1 are ignored. No sign handling: the bit pattern is streamed as given.

Optional Feature:
- Macro STRIPES_SER_ZERO_SKIP_EN.
- With the macro defined:
  - A brick whose Tn neurons are all zero in bits [p-1:0] is accepted (handshake completes) but is never loaded into either slot.
  - A 1-cycle pulse is emitted on an added output o_skipped, one cycle after accept.
  - No o_valid cycles are produced for that brick.
- Without the macro, zero bricks are streamed normally and the o_skipped port does not exist.

Decomposition:
- Shared package stripes_pkg holds:
  - constants N, Tn, PW
  - function prec_decode (0/overflow -> N)
  - FSM state typedef {IDLE, STREAM}
- One natural sub-module, stripes_brick_slot: a brick + precision register with load/clear/full. It is instantiated twice (active, pending).

Test Plan:
- Single brick, all lanes 0xA5, precision 8, no stall -> o_valid for 8 cycles; each lane emits 1,0,1,0,0,1,0,1; o_first_cycle on cycle 1 only; o_last_cycle on cycle 8; o_bit_idx 7..0.
- Three bricks offered back-to-back, precision 4 (0x0F, 0x00, 0x09 in all lanes) -> 12 contiguous o_valid cycles with no gap; o_ready drops while pending is full.
- Precision 0 and precision 20 with lane 0 = 0x8001 -> both stream 16 bits; lane 0 bit 1 on first and last cycle, 0 between.
- Precision 1, lanes alternate 0x0001/0x0000 -> a single cycle with o_first_cycle=o_last_cycle=1; o_bits=0x5555.
- i_stall high for 3 cycles at bit_idx 5 of an 8-bit brick -> outputs frozen at idx 5 for 3 cycles; total 11 valid cycles; a pending accept during the stall succeeds.
- reset=0 for one cycle at bit_idx 3 of a brick with a pending brick queued -> o_valid=0 next cycle; o_ready=1; neither brick is ever streamed.
